// File: rtl/video_pll_pkg.sv
// -----------------------------------------------------------------------------
// video_pll_pkg
// Shared definitions for the video PLL reset controller: the controller state
// encoding, default cycle parameters and a width helper used to size timers.
// -----------------------------------------------------------------------------
package video_pll_pkg;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } video_pll_state_e;

  localparam int unsigned DEF_PLL_RST_CYCLES      = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int unsigned DEF_RELEASE_DELAY       = 8;
  localparam int unsigned DEF_CNT_W               = 8;

  // Bits needed for a counter that runs 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/video_pll_sync2.sv
// -----------------------------------------------------------------------------
// video_pll_sync2
// Generic two-flop synchroniser for asynchronous status inputs.
// Ports:
//   i_clk  - destination clock
//   i_rst  - synchronous active-high reset, both flops clear to 0
//   i_d    - asynchronous input bus
//   o_q    - synchronised output (two clock cycles of latency)
// -----------------------------------------------------------------------------
module video_pll_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/video_pll_reset_ctrl.sv
// -----------------------------------------------------------------------------
// video_pll_reset_ctrl
// Reference-clock side of the video PLL rst/locked handshake. Pulses the PLL
// reset, qualifies the synchronised lock indication, releases the video domain
// reset once lock has been stable, and re-runs the sequence on lock loss,
// lock timeout or a software request.
//
// Optional feature macro: VIDEO_PLL_RESET_CTRL_STATUS_EN
//   defined   - retry_count / loss_count are saturating status counters
//   undefined - both ports are tied to 0 and no counter flops exist
//
// Ports:
//   refclk       - 50 MHz reference clock, all logic in this domain
//   rst          - synchronous active-high reset
//   pll_locked   - PLL lock, asynchronous to refclk
//   sw_reset_req - single-cycle request to restart the PLL sequence
//   pll_rst      - PLL reset, active-high (registered)
//   video_rst    - video domain reset, active-high (registered)
//   video_ready  - high only in RUN (registered)
//   retry_count  - lock-timeout retries, saturating
//   loss_count   - lock losses after acceptance, saturating
//   dbg_state    - current controller state for observation
//
// Handshake: sw_reset_req is a one-cycle pulse sampled on every refclk edge;
// there is no ready/ack, a request is always accepted on the edge it is seen.
// -----------------------------------------------------------------------------
module video_pll_reset_ctrl
  import video_pll_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned RELEASE_DELAY       = DEF_RELEASE_DELAY,
  parameter int unsigned CNT_W               = DEF_CNT_W
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             sw_reset_req,
  output logic             pll_rst,
  output logic             video_rst,
  output logic             video_ready,
  output logic [CNT_W-1:0] retry_count,
  output logic [CNT_W-1:0] loss_count,
  output video_pll_state_e dbg_state
);

  // One phase timer serves as the RESET_PLL length counter, the WAIT_LOCK
  // timeout counter and the RELEASE delay counter; it clears on state entry.
  localparam int unsigned TMR_W = cnt_width(max3(PLL_RST_CYCLES,
                                                 LOCK_TIMEOUT_CYCLES,
                                                 RELEASE_DELAY));
  localparam int unsigned STB_W = cnt_width(LOCK_STABLE_CYCLES);

  localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] REL_LAST     = TMR_W'(RELEASE_DELAY - 1);
  localparam logic [STB_W-1:0] STABLE_LAST  = STB_W'(LOCK_STABLE_CYCLES - 1);

  video_pll_state_e r_state;
  video_pll_state_e w_next_state;
  logic [TMR_W-1:0] r_timer;
  logic [STB_W-1:0] r_stable_cnt;
  logic             r_pll_rst;
  logic             r_video_rst;
  logic             r_video_ready;
  logic             w_locked_s;
  logic             w_entry;
  logic             w_retry_inc;
  logic             w_loss_inc;

  video_pll_sync2 #(.WIDTH(1)) u_lock_sync (
    .i_clk (refclk),
    .i_rst (rst),
    .i_d   (pll_locked),
    .o_q   (w_locked_s)
  );

  // Next-state logic. sw_reset_req outranks lock loss and timeout; within
  // WAIT_LOCK an accepted lock outranks a simultaneous timeout.
  always_comb begin
    w_next_state = r_state;
    w_retry_inc  = 1'b0;
    w_loss_inc   = 1'b0;
    if (sw_reset_req) begin
      w_next_state = RESET_PLL;
    end else begin
      case (r_state)
        RESET_PLL: begin
          if (r_timer == RST_LAST) w_next_state = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          // Counter holds the locked cycles before this one, so this is the
          // LOCK_STABLE_CYCLES-th consecutive locked cycle.
          if (w_locked_s && (r_stable_cnt == STABLE_LAST)) begin
            w_next_state = RELEASE;
          end else if (r_timer == TIMEOUT_LAST) begin
            w_next_state = RESET_PLL;
            w_retry_inc  = 1'b1;
          end
        end
        RELEASE: begin
          if (!w_locked_s) begin
            w_next_state = RESET_PLL;
            w_loss_inc   = 1'b1;
          end else if (r_timer == REL_LAST) begin
            w_next_state = RUN;
          end
        end
        RUN: begin
          if (!w_locked_s) begin
            w_next_state = RESET_PLL;
            w_loss_inc   = 1'b1;
          end
        end
        default: w_next_state = RESET_PLL;
      endcase
    end
  end

  // A software request re-enters RESET_PLL even from RESET_PLL, restarting
  // the reset pulse.
  assign w_entry = sw_reset_req || (w_next_state != r_state);

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state <= RESET_PLL;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst || w_entry) begin
      r_timer <= '0;
    end else if (r_state != RUN) begin
      r_timer <= r_timer + TMR_W'(1);
    end
  end

  always_ff @(posedge refclk) begin
    if (rst || w_entry || (r_state != WAIT_LOCK) || !w_locked_s) begin
      r_stable_cnt <= '0;
    end else begin
      r_stable_cnt <= r_stable_cnt + STB_W'(1);
    end
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_pll_rst     <= 1'b1;
      r_video_rst   <= 1'b1;
      r_video_ready <= 1'b0;
    end else begin
      r_pll_rst     <= (w_next_state == RESET_PLL);
      r_video_rst   <= (w_next_state != RUN);
      r_video_ready <= (w_next_state == RUN);
    end
  end

  assign pll_rst     = r_pll_rst;
  assign video_rst   = r_video_rst;
  assign video_ready = r_video_ready;
  assign dbg_state   = r_state;

`ifdef VIDEO_PLL_RESET_CTRL_STATUS_EN
  logic [CNT_W-1:0] r_retry_count;
  logic [CNT_W-1:0] r_loss_count;

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_retry_count <= '0;
      r_loss_count  <= '0;
    end else begin
      if (w_retry_inc && (r_retry_count != '1)) begin
        r_retry_count <= r_retry_count + CNT_W'(1);
      end
      if (w_loss_inc && (r_loss_count != '1)) begin
        r_loss_count <= r_loss_count + CNT_W'(1);
      end
    end
  end

  assign retry_count = r_retry_count;
  assign loss_count  = r_loss_count;
`else
  logic w_unused_status;
  assign w_unused_status = w_retry_inc | w_loss_inc;
  assign retry_count     = '0;
  assign loss_count      = '0;
`endif

endmodule

// File: tb/tb_video_pll_reset_ctrl.sv
// -----------------------------------------------------------------------------
// tb_video_pll_reset_ctrl
// Directed and randomised stimulus for video_pll_reset_ctrl, checked every
// cycle against a behavioural model kept in phase/elapsed-time terms.
// -----------------------------------------------------------------------------
module tb_video_pll_reset_ctrl;
  import video_pll_pkg::*;

  localparam int P_RST     = 4;
  localparam int P_STABLE  = 8;
  localparam int P_TIMEOUT = 64;
  localparam int P_REL     = 2;
  localparam int P_CNT_W   = 8;
  localparam int CNT_MAX   = (1 << P_CNT_W) - 1;
`ifdef VIDEO_PLL_RESET_CTRL_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic refclk = 1'b0;
  always #10 refclk = ~refclk;

  logic               rst;
  logic               pll_locked;
  logic               sw_reset_req;
  logic               pll_rst;
  logic               video_rst;
  logic               video_ready;
  logic [P_CNT_W-1:0] retry_count;
  logic [P_CNT_W-1:0] loss_count;
  video_pll_state_e   dbg_state;

  video_pll_reset_ctrl #(
    .PLL_RST_CYCLES      (P_RST),
    .LOCK_STABLE_CYCLES  (P_STABLE),
    .LOCK_TIMEOUT_CYCLES (P_TIMEOUT),
    .RELEASE_DELAY       (P_REL),
    .CNT_W               (P_CNT_W)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .sw_reset_req (sw_reset_req),
    .pll_rst      (pll_rst),
    .video_rst    (video_rst),
    .video_ready  (video_ready),
    .retry_count  (retry_count),
    .loss_count   (loss_count),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase, cycles spent in it, the locked_s history since entry and a
  // two-deep delay line standing in for the synchroniser latency.
  video_pll_state_e m_state = RESET_PLL;
  int m_elapsed = 0;
  bit m_hist[$];
  bit m_pipe[$];
  int m_retry = 0;
  int m_loss  = 0;

  function automatic int trailing_ones();
    int n = 0;
    for (int i = m_hist.size() - 1; i >= 0; i--) begin
      if (!m_hist[i]) break;
      n++;
    end
    return n;
  endfunction

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic model_step();
    bit ls;
    bit entered;
    video_pll_state_e nxt;
    if (rst) begin
      m_state   = RESET_PLL;
      m_elapsed = 0;
      m_hist.delete();
      m_pipe.delete();
      m_pipe.push_back(1'b0);
      m_pipe.push_back(1'b0);
      m_retry = 0;
      m_loss  = 0;
      cyc     = 0;
      return;
    end
    cyc++;
    ls = m_pipe[0];
    m_hist.push_back(ls);
    nxt     = m_state;
    entered = 1'b0;
    if (sw_reset_req) begin
      nxt     = RESET_PLL;
      entered = 1'b1;
    end else begin
      case (m_state)
        RESET_PLL: if (m_elapsed + 1 == P_RST) nxt = WAIT_LOCK;
        WAIT_LOCK: begin
          if (ls && trailing_ones() >= P_STABLE) nxt = RELEASE;
          else if (m_elapsed + 1 == P_TIMEOUT) begin
            nxt     = RESET_PLL;
            m_retry = sat(m_retry + 1);
          end
        end
        RELEASE: begin
          if (!ls) begin
            nxt    = RESET_PLL;
            m_loss = sat(m_loss + 1);
          end else if (m_elapsed + 1 == P_REL) nxt = RUN;
        end
        default: begin
          if (!ls) begin
            nxt    = RESET_PLL;
            m_loss = sat(m_loss + 1);
          end
        end
      endcase
    end
    if (entered || nxt != m_state) begin
      m_elapsed = 0;
      m_hist.delete();
    end else begin
      m_elapsed++;
    end
    m_state = nxt;
    m_pipe.push_back(pll_locked);
    void'(m_pipe.pop_front());
  endtask

  task automatic check_outputs();
    chk("state",       32'(dbg_state),   32'(m_state));
    chk("pll_rst",     32'(pll_rst),     32'(m_state == RESET_PLL));
    chk("video_rst",   32'(video_rst),   32'(m_state != RUN));
    chk("video_ready", 32'(video_ready), 32'(m_state == RUN));
    chk("retry_count", 32'(retry_count), STATUS_EN ? 32'(m_retry) : 32'd0);
    chk("loss_count",  32'(loss_count),  STATUS_EN ? 32'(m_loss) : 32'd0);
  endtask

  // ---------------- driver ----------------
  // Inputs change only at the falling edge; the model consumes them at the
  // rising edge and outputs are compared at the next falling edge.
  task automatic tick();
    @(posedge refclk);
    model_step();
    @(negedge refclk);
    check_outputs();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int   last_hi;
    int   first_rel;
    int   lat;
    int   rises;
    int   found;
    int   run_left;
    bit   seen_rel;
    bit   vr_low;
    logic prev_rst;

    rst          = 1'b1;
    pll_locked   = 1'b0;
    sw_reset_req = 1'b0;

    // Clean bring-up: lock raised at cycle 10.
    repeat (3) tick();
    chk("reset_pll_rst",     32'(pll_rst),     32'd1);
    chk("reset_video_rst",   32'(video_rst),   32'd1);
    chk("reset_video_ready", 32'(video_ready), 32'd0);
    chk("reset_state",       32'(dbg_state),   32'(RESET_PLL));
    rst       = 1'b0;
    last_hi   = -1;
    first_rel = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (pll_rst) last_hi = cyc;
      if (!video_rst && first_rel < 0) first_rel = cyc;
      if (cyc == 10) pll_locked = 1'b1;
    end
    chk("bringup_pll_rst_last",  32'(last_hi),     32'd3);
    chk("bringup_release_cycle", 32'(first_rel),   32'd22);
    chk("bringup_ready",         32'(video_ready), 32'd1);
    chk("bringup_retry",         32'(retry_count), 32'd0);
    chk("bringup_loss",          32'(loss_count),  32'd0);

    // One-cycle lock loss in RUN.
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    lat = video_rst ? 1 : -1;
    for (int i = 2; i <= 6; i++) begin
      tick();
      if (video_rst && lat < 0) lat = i;
    end
    chk("loss_latency", 32'(lat), 32'd3);
    repeat (30) tick();
    chk("relock_ready", 32'(video_ready), 32'd1);
    chk("loss_count_one", 32'(loss_count), STATUS_EN ? 32'd1 : 32'd0);

    // Glitchy lock: 5-cycle toggles never reach 8 stable cycles.
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    seen_rel = 1'b0;
    for (int i = 0; i < 40; i++) begin
      pll_locked = ((i / 5) % 2 == 0);
      tick();
      if (dbg_state == RELEASE) seen_rel = 1'b1;
    end
    pll_locked = 1'b1;
    found = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (dbg_state == RELEASE && found < 0) found = cyc;
    end
    chk("glitch_no_release", 32'(seen_rel), 32'd0);
    chk("glitch_accept_cycle", 32'(found), 32'd50);

    // Timeout retry with lock held low.
    rst        = 1'b1;
    pll_locked = 1'b0;
    tick();
    rst      = 1'b0;
    prev_rst = pll_rst;
    rises    = 0;
    vr_low   = 1'b0;
    for (int i = 0; i < 206; i++) begin
      tick();
      if (pll_rst && !prev_rst) rises++;
      prev_rst = pll_rst;
      if (!video_rst) vr_low = 1'b1;
    end
    chk("timeout_pll_rst_pulses", 32'(rises), 32'd3);
    chk("timeout_video_rst_held", 32'(vr_low), 32'd0);
    chk("timeout_retry_count", 32'(retry_count), STATUS_EN ? 32'd3 : 32'd0);

    // Software restart in RUN, then coinciding with a lock loss.
    rst        = 1'b1;
    pll_locked = 1'b1;
    tick();
    rst = 1'b0;
    repeat (30) tick();
    chk("sw_pre_ready", 32'(video_ready), 32'd1);
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    chk("sw_state",   32'(dbg_state),  32'(RESET_PLL));
    chk("sw_pll_rst", 32'(pll_rst),    32'd1);
    chk("sw_loss",    32'(loss_count), 32'd0);
    repeat (30) tick();
    chk("sw_relock_ready", 32'(video_ready), 32'd1);
    pll_locked = 1'b0;
    tick();
    tick();
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    pll_locked   = 1'b1;
    chk("sw_with_loss_state", 32'(dbg_state),  32'(RESET_PLL));
    chk("sw_with_loss_count", 32'(loss_count), 32'd0);

    // rst asserted while in RELEASE, after one counted loss.
    repeat (30) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    found = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dbg_state == RELEASE) begin
        found = cyc;
        break;
      end
    end
    chk("mid_release_reached", 32'(found >= 0), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_release_state",     32'(dbg_state),   32'(RESET_PLL));
    chk("mid_release_pll_rst",   32'(pll_rst),     32'd1);
    chk("mid_release_video_rst", 32'(video_rst),   32'd1);
    chk("mid_release_ready",     32'(video_ready), 32'd0);
    chk("mid_release_retry",     32'(retry_count), 32'd0);
    chk("mid_release_loss",      32'(loss_count),  32'd0);

    // Randomised lock runs with sparse software restarts.
    run_left = 0;
    for (int i = 0; i < 800; i++) begin
      if (run_left == 0) begin
        pll_locked = 1'($urandom_range(0, 1));
        run_left   = $urandom_range(1, 40);
      end
      run_left--;
      sw_reset_req = ($urandom_range(0, 63) == 0);
      tick();
    end
    sw_reset_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
